// File: rtl/lorenz_stream_packer.sv
// lorenz_stream_packer
//
// Decimates the Lorenz generator's x/y/z state stream, buffers kept triples
// in a small FIFO and sends each one as a four-word packet
// (header, x, y, z) on a valid/ready stream. When the FIFO is full, kept
// samples are dropped, counted in a saturating counter and flagged in a
// sticky overflow bit.
//
// Parameters:
//   BITLENGTH  sample / stream word width (>= 16)
//   DEPTH      FIFO depth in triples (power of two, >= 2)
//   DECIM      keep one sample in every DECIM (1..255)
//
// Ports:
//   clk        rising-edge system clock
//   rst        asynchronous reset, active low
//   in_valid   x/y/z carry a new generator step this cycle
//   x, y, z    signed state samples, passed through bit-exact
//   out_ready  downstream accepts out_data this cycle
//   out_valid  out_data holds a packet word
//   out_data   packet word: {8'hA5, seq} header, then x, y, z
//   out_last   high on the z word, the final word of a packet
//   dropped    saturating count of kept samples lost to a full FIFO
//   overflow   sticky flag, set on the first drop

module lorenz_stream_packer #(
  parameter int BITLENGTH = 16,
  parameter int DEPTH     = 4,
  parameter int DECIM     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [BITLENGTH-1:0] x,
  input  logic [BITLENGTH-1:0] y,
  input  logic [BITLENGTH-1:0] z,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [BITLENGTH-1:0] out_data,
  output logic                 out_last,
  output logic [7:0]           dropped,
  output logic                 overflow
);

  localparam int             AW         = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_COUNT = DEPTH[AW:0];
  localparam logic [AW:0]    ONE_COUNT  = 1;
  localparam logic [AW-1:0]  ONE_PTR    = 1;
  localparam logic [7:0]     DCNT_LAST  = DECIM[7:0] - 8'd1;

  typedef enum logic [2:0] {IDLE, HDR, XW, YW, ZW} state_t;

  logic [7:0]           seq_mem [DEPTH];
  logic [BITLENGTH-1:0] x_mem   [DEPTH];
  logic [BITLENGTH-1:0] y_mem   [DEPTH];
  logic [BITLENGTH-1:0] z_mem   [DEPTH];

  logic [AW-1:0]        wptr;
  logic [AW-1:0]        rptr;
  logic [AW-1:0]        rptr_next;
  logic [AW:0]          count;
  logic [7:0]           seq;
  logic [7:0]           dcnt;

  logic                 keep;
  logic                 full;
  logic                 wr_en;
  logic                 pop;

  state_t               state;
  state_t               state_nx;
  logic                 valid_nx;
  logic                 last_nx;
  logic [BITLENGTH-1:0] data_nx;
  logic [BITLENGTH-1:0] hdr_head;
  logic [BITLENGTH-1:0] hdr_after;

  // Fullness uses the registered occupancy only, so a pop in the same
  // cycle never frees a slot for the incoming sample.
  assign keep      = in_valid && (dcnt == 8'd0);
  assign full      = (count == FULL_COUNT);
  assign wr_en     = keep && !full;
  assign pop       = (state == ZW) && out_ready;
  assign rptr_next = rptr + ONE_PTR;

  // Decimation phase counter; the sample seen at phase 0 is the one kept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dcnt <= 8'd0;
    end else if (in_valid) begin
      dcnt <= (dcnt == DCNT_LAST) ? 8'd0 : dcnt + 8'd1;
    end
  end

  // Write side bookkeeping: sequence number advances only on a real write,
  // a kept sample that finds the FIFO full is counted as a drop instead.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr     <= '0;
      seq      <= 8'd0;
      dropped  <= 8'd0;
      overflow <= 1'b0;
    end else if (wr_en) begin
      wptr <= wptr + ONE_PTR;
      seq  <= seq + 8'd1;
    end else if (keep) begin
      overflow <= 1'b1;
      if (dropped != 8'hFF) begin
        dropped <= dropped + 8'd1;
      end
    end
  end

  // FIFO storage carries no reset; entries are only read once written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      seq_mem[wptr] <= seq;
      x_mem[wptr]   <= x;
      y_mem[wptr]   <= y;
      z_mem[wptr]   <= z;
    end
  end

  // Read pointer and occupancy; simultaneous write and pop cancel out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rptr  <= '0;
      count <= '0;
    end else begin
      if (pop) begin
        rptr <= rptr_next;
      end
      case ({wr_en, pop})
        2'b10:   count <= count + ONE_COUNT;
        2'b01:   count <= count - ONE_COUNT;
        default: count <= count;
      endcase
    end
  end

  // Header words for the current head and for the entry behind it; the
  // latter is needed when a ZW pop rolls straight into the next packet.
  always_comb begin
    hdr_head         = '0;
    hdr_head[15:0]   = {8'hA5, seq_mem[rptr]};
    hdr_after        = '0;
    hdr_after[15:0]  = {8'hA5, seq_mem[rptr_next]};
  end

  // Next state and next output word. Outputs are registered alongside the
  // state, so out_ready only steers what gets loaded at the next edge and
  // a stalled word holds by default.
  always_comb begin
    state_nx = state;
    valid_nx = out_valid;
    data_nx  = out_data;
    last_nx  = out_last;
    case (state)
      IDLE: begin
        if (count != '0) begin
          state_nx = HDR;
          valid_nx = 1'b1;
          data_nx  = hdr_head;
          last_nx  = 1'b0;
        end
      end
      HDR: begin
        if (out_ready) begin
          state_nx = XW;
          data_nx  = x_mem[rptr];
        end
      end
      XW: begin
        if (out_ready) begin
          state_nx = YW;
          data_nx  = y_mem[rptr];
        end
      end
      YW: begin
        if (out_ready) begin
          state_nx = ZW;
          data_nx  = z_mem[rptr];
          last_nx  = 1'b1;
        end
      end
      ZW: begin
        if (out_ready) begin
          last_nx = 1'b0;
          if (count > ONE_COUNT) begin
            state_nx = HDR;
            data_nx  = hdr_after;
          end else begin
            state_nx = IDLE;
            valid_nx = 1'b0;
            data_nx  = '0;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        valid_nx = 1'b0;
        data_nx  = '0;
        last_nx  = 1'b0;
      end
    endcase
  end

  // State and stream output registers; reset aborts any packet in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_nx;
      out_valid <= valid_nx;
      out_data  <= data_nx;
      out_last  <= last_nx;
    end
  end

endmodule

// File: tb/tb_lorenz_stream_packer.sv
// Testbench for lorenz_stream_packer. A DECIM=1 instance covers the packet
// format, latency, backpressure, overflow, reset abort, sequence wrap and
// drop saturation; a DECIM=3 instance covers decimation.

module tb_lorenz_stream_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        in_valid;
  logic [15:0] x, y, z;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_last;
  logic [7:0]  dropped;
  logic        overflow;

  logic        in_valid3;
  logic [15:0] x3, y3, z3;
  logic        out_ready3;
  logic        out_valid3;
  logic [15:0] out_data3;
  logic        out_last3;
  logic [7:0]  dropped3;
  logic        overflow3;

  always #5 clk = ~clk;

  lorenz_stream_packer #(.BITLENGTH(16), .DEPTH(4), .DECIM(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .y(y), .z(z),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .dropped(dropped), .overflow(overflow)
  );

  lorenz_stream_packer #(.BITLENGTH(16), .DEPTH(4), .DECIM(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .x(x3), .y(y3), .z(z3),
    .out_ready(out_ready3), .out_valid(out_valid3), .out_data(out_data3),
    .out_last(out_last3), .dropped(dropped3), .overflow(overflow3)
  );

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    logic        kept;
    logic [15:0] hdr;
  } vec_t;

  int          compared = 0;
  int          mismatched = 0;
  logic [16:0] exp_q[$];
  logic [16:0] got3[$];
  logic [16:0] exp3[$];
  logic [7:0]  exp_seq = 8'd0;
  int          words = 0;
  int          gaps = 0;
  logic [15:0] last_hdr = 16'h0000;
  vec_t        ovf_tab[6];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Stream scoreboard: every valid cycle must show the word at the front of
  // the expected queue (this also covers stability under stall); a
  // handshake retires it.
  always @(negedge clk) begin
    if (rst) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_word: got %h, expected no output", out_data);
        end else begin
          checkOutput("stream_data", {16'd0, out_data}, {16'd0, exp_q[0][15:0]});
          checkOutput("stream_last", {31'd0, out_last}, {31'd0, exp_q[0][16]});
          if (out_ready) begin
            if (words % 4 == 0) last_hdr = out_data;
            words++;
            void'(exp_q.pop_front());
          end
        end
      end else if (words > 0 && exp_q.size() != 0) begin
        gaps++;
      end
    end
  end

  // Capture of the decimating instance's handshaken words.
  always @(negedge clk) begin
    if (rst && out_valid3 && out_ready3) got3.push_back({out_last3, out_data3});
  end

  task automatic pushPacket(input logic [15:0] hdr, input logic [15:0] sx,
                            input logic [15:0] sy, input logic [15:0] sz);
    exp_q.push_back({1'b0, hdr});
    exp_q.push_back({1'b0, sx});
    exp_q.push_back({1'b0, sy});
    exp_q.push_back({1'b1, sz});
  endtask

  task automatic applyStimulus(input logic [15:0] sx, input logic [15:0] sy,
                               input logic [15:0] sz);
    in_valid = 1'b1;
    x = sx;
    y = sy;
    z = sz;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic keepSample(input logic [15:0] sx, input logic [15:0] sy,
                            input logic [15:0] sz);
    pushPacket({8'hA5, exp_seq}, sx, sy, sz);
    exp_seq = exp_seq + 8'd1;
    applyStimulus(sx, sy, sz);
  endtask

  task automatic doReset();
    #2;
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    exp_seq = 8'd0;
    words = 0;
    gaps = 0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain(input int limit, input string name);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= limit) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s: timeout after %0d cycles, %0d words still expected",
               name, limit, exp_q.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    ovf_tab[0] = '{16'h1111, 16'h2222, 16'h3333, 1'b1, 16'hA500};
    ovf_tab[1] = '{16'h4444, 16'h5555, 16'h6666, 1'b1, 16'hA501};
    ovf_tab[2] = '{16'h7777, 16'h8888, 16'h9999, 1'b1, 16'hA502};
    ovf_tab[3] = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 1'b1, 16'hA503};
    ovf_tab[4] = '{16'hDDDD, 16'hEEEE, 16'hFFFF, 1'b0, 16'h0000};
    ovf_tab[5] = '{16'h0F0F, 16'hF0F0, 16'h1234, 1'b0, 16'h0000};

    in_valid = 1'b0; x = '0; y = '0; z = '0; out_ready = 1'b0;
    in_valid3 = 1'b0; x3 = '0; y3 = '0; z3 = '0; out_ready3 = 1'b1;

    // Reset values, observed while reset is held.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_out_data", {16'd0, out_data}, 32'd0);
    checkOutput("rst_out_last", {31'd0, out_last}, 32'd0);
    checkOutput("rst_dropped", {24'd0, dropped}, 32'd0);
    checkOutput("rst_overflow", {31'd0, overflow}, 32'd0);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Decimation: seven consecutive samples into the DECIM=3 instance.
    for (int i = 0; i < 7; i++) begin
      in_valid3 = 1'b1;
      x3 = 16'h0100 + 16'(i);
      y3 = 16'h0200 + 16'(i);
      z3 = 16'h0300 + 16'(i);
      @(posedge clk);
      #1;
    end
    in_valid3 = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    begin
      logic [7:0] k = 8'd0;
      for (int i = 0; i < 7; i++) begin
        if (i % 3 == 0) begin
          exp3.push_back({1'b0, 8'hA5, k});
          exp3.push_back({1'b0, 16'h0100 + 16'(i)});
          exp3.push_back({1'b0, 16'h0200 + 16'(i)});
          exp3.push_back({1'b1, 16'h0300 + 16'(i)});
          k = k + 8'd1;
        end
      end
    end
    checkOutput("decim_words", got3.size(), exp3.size());
    for (int j = 0; j < exp3.size() && j < got3.size(); j++)
      checkOutput("decim_word", {15'd0, got3[j]}, {15'd0, exp3[j]});
    checkOutput("decim_dropped", {24'd0, dropped3}, 32'd0);

    // Single sample: latency and packet contents.
    doReset();
    out_ready = 1'b1;
    keepSample(16'h0002, 16'h0003, 16'h8003);
    checkOutput("lat_n1_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("lat_n2_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("lat_n2_data", {16'd0, out_data}, 32'h0000A500);
    waitDrain(20, "single_drain");
    checkOutput("single_words", words, 4);

    // Backpressure while the x word is presented.
    doReset();
    keepSample(16'h0002, 16'h0003, 16'h8003);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checkOutput("bp_data", {16'd0, out_data}, 32'h00000002);
      checkOutput("bp_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("bp_last", {31'd0, out_last}, 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    waitDrain(20, "bp_drain");
    checkOutput("bp_words", words, 4);

    // Overflow: six kept samples with the stream stalled.
    doReset();
    for (int i = 0; i < 6; i++) begin
      if (ovf_tab[i].kept) pushPacket(ovf_tab[i].hdr, ovf_tab[i].x, ovf_tab[i].y, ovf_tab[i].z);
      applyStimulus(ovf_tab[i].x, ovf_tab[i].y, ovf_tab[i].z);
    end
    checkOutput("ovf_dropped", {24'd0, dropped}, 32'd2);
    checkOutput("ovf_overflow", {31'd0, overflow}, 32'd1);
    out_ready = 1'b1;
    waitDrain(60, "ovf_drain");
    checkOutput("ovf_words", words, 16);
    checkOutput("ovf_overflow_sticky", {31'd0, overflow}, 32'd1);
    checkOutput("ovf_dropped_after", {24'd0, dropped}, 32'd2);

    // Reset asserted while the y word is presented.
    doReset();
    keepSample(16'h0004, 16'h0005, 16'h0006);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("yw_data", {16'd0, out_data}, 32'h00000005);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("rst_async_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_async_data", {16'd0, out_data}, 32'd0);
    exp_q.delete();
    exp_seq = 8'd0;
    words = 0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      checkOutput("post_rst_idle", {31'd0, out_valid}, 32'd0);
    end
    keepSample(16'h0007, 16'h0008, 16'h0009);
    waitDrain(20, "post_rst_drain");
    checkOutput("post_rst_words", words, 4);

    // Sequence wrap at full throughput: one sample every four cycles.
    doReset();
    out_ready = 1'b1;
    for (int p = 0; p < 257; p++) begin
      keepSample(16'(p), ~16'(p), 16'(p) ^ 16'h8000);
      repeat (3) @(posedge clk);
      #1;
    end
    waitDrain(100, "wrap_drain");
    checkOutput("wrap_words", words, 257 * 4);
    checkOutput("wrap_last_hdr", {16'd0, last_hdr}, 32'h0000A500);
    checkOutput("wrap_gaps", gaps, 0);
    checkOutput("wrap_dropped", {24'd0, dropped}, 32'd0);

    // Drop counter saturation: fill the FIFO, then 300 drops.
    doReset();
    for (int i = 0; i < 4; i++) keepSample(16'(i), 16'(i + 10), 16'(i + 20));
    for (int i = 0; i < 300; i++) applyStimulus(16'(i), 16'h7FFF, 16'h8000);
    checkOutput("sat_dropped", {24'd0, dropped}, 32'd255);
    checkOutput("sat_overflow", {31'd0, overflow}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
